// File: rtl/ip_udp_hdr_gen_if.sv
// Handshake bundle for ip_udp_hdr_gen.
// Carries the metadata FIFO pop side and the header AXI-Stream output.
interface ip_udp_hdr_gen_if;
    logic         meta_in_valid;
    logic         meta_in_ready;
    logic [191:0] meta_in_bus;
    logic [31:0]  m_axis_tdata;
    logic [3:0]   m_axis_tkeep;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;

    modport master (
        input  meta_in_valid,
        input  meta_in_bus,
        input  m_axis_tready,
        output meta_in_ready,
        output m_axis_tdata,
        output m_axis_tkeep,
        output m_axis_tvalid,
        output m_axis_tlast
    );

    modport slave (
        output meta_in_valid,
        output meta_in_bus,
        output m_axis_tready,
        input  meta_in_ready,
        input  m_axis_tdata,
        input  m_axis_tkeep,
        input  m_axis_tvalid,
        input  m_axis_tlast
    );
endinterface

// File: rtl/ip_udp_hdr_gen.sv
// IPv4+UDP header generator: pops one packed metadata entry, computes the IPv4
// header checksum and emits the 28-byte header as seven 32-bit stream beats.
module ip_udp_hdr_gen #(
    parameter logic [7:0]  TTL        = 8'd64,
    parameter logic [15:0] IDENT_INIT = 16'h0000
) (
    input  logic             clk,
    input  logic             rstn,
    ip_udp_hdr_gen_if.master hdr,
    output logic [15:0]      hdr_dst_index,
    output logic [15:0]      hdr_payload_len,
    output logic             busy,
    output logic             drop_pulse
);
    typedef enum logic [2:0] {IDLE, SUM, FOLD, SEND, DROP} state_t;

    state_t      state;
    state_t      next_state;

    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic        df;
    logic [15:0] ident;
    logic [19:0] sum;
    logic [15:0] csum;
    logic [2:0]  beat;

    logic        accept;
    logic        oversize;
    logic        beat_done;
    logic        last_beat;
    logic [15:0] total_len;
    logic [15:0] udp_len;
    logic [15:0] frag;
    logic [16:0] sum1;
    logic [31:0] beat_data;
    logic        unused_meta;

    assign accept      = hdr.meta_in_valid & hdr.meta_in_ready;
    assign oversize    = hdr.meta_in_bus[159:128] > 32'd65507;
    assign beat_done   = hdr.m_axis_tvalid & hdr.m_axis_tready;
    assign last_beat   = (beat == 3'd6);
    assign total_len   = 16'd28 + hdr_payload_len;
    assign udp_len     = 16'd8 + hdr_payload_len;
    assign frag        = df ? 16'h4000 : 16'h0000;
    assign sum1        = {1'b0, sum[15:0]} + {13'd0, sum[19:16]};
    assign unused_meta = ^{hdr.meta_in_bus[191:176], hdr.meta_in_bus[175:161],
                           hdr.meta_in_bus[47:32]};

    // Ready is masked by rstn so nothing is popped while reset is held.
    assign hdr.meta_in_ready = rstn & (state == IDLE);
    assign hdr.m_axis_tvalid = (state == SEND);
    assign hdr.m_axis_tlast  = (state == SEND) & last_beat;
    assign hdr.m_axis_tkeep  = 4'hF;
    assign hdr.m_axis_tdata  = (state == SEND) ? beat_data : 32'h0;
    assign busy              = (state != IDLE);
    assign drop_pulse        = (state == DROP);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    next_state = oversize ? DROP : SUM;
                end
            end
            SUM:  next_state = FOLD;
            FOLD: next_state = SEND;
            SEND: begin
                if (beat_done && last_beat) begin
                    next_state = IDLE;
                end
            end
            DROP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        beat_data = 32'h0;
        unique case (beat)
            3'd0: beat_data = {8'h45, 8'h00, total_len};
            3'd1: beat_data = {ident, frag};
            3'd2: beat_data = {TTL, 8'h11, csum};
            3'd3: beat_data = src_ip;
            3'd4: beat_data = dst_ip;
            3'd5: beat_data = {src_port, dst_port};
            3'd6: beat_data = {udp_len, 16'h0000};
            default: beat_data = 32'h0;
        endcase
    end

    // Fields are captured on every accept, including ones that end up dropped.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            src_ip          <= 32'h0;
            dst_ip          <= 32'h0;
            src_port        <= 16'h0;
            dst_port        <= 16'h0;
            df              <= 1'b0;
            hdr_dst_index   <= 16'h0;
            hdr_payload_len <= 16'h0;
            ident           <= IDENT_INIT;
            sum             <= 20'h0;
            csum            <= 16'h0;
            beat            <= 3'd0;
        end else begin
            if (accept) begin
                df              <= hdr.meta_in_bus[160];
                hdr_payload_len <= hdr.meta_in_bus[143:128];
                dst_ip          <= hdr.meta_in_bus[127:96];
                src_ip          <= hdr.meta_in_bus[95:64];
                hdr_dst_index   <= hdr.meta_in_bus[63:48];
                dst_port        <= hdr.meta_in_bus[31:16];
                src_port        <= hdr.meta_in_bus[15:0];
                beat            <= 3'd0;
            end
            if (state == SUM) begin
                sum <= 20'h04500 + 20'(total_len) + 20'(ident) + 20'(frag)
                     + 20'({TTL, 8'h11}) + 20'(src_ip[31:16]) + 20'(src_ip[15:0])
                     + 20'(dst_ip[31:16]) + 20'(dst_ip[15:0]);
            end
            if (state == FOLD) begin
                csum <= ~(sum1[15:0] + 16'(sum1[16]));
            end
            if ((state == SEND) && beat_done) begin
                if (last_beat) begin
                    beat  <= 3'd0;
                    ident <= ident + 16'd1;
                end else begin
                    beat <= beat + 3'd1;
                end
            end
        end
    end
endmodule
